// File: rtl/led_ctrl_pkg.sv
// Shared types and default constants for the LED display scheduler.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SHOW = 2'd2
  } sched_state_t;

  localparam int DEF_N           = 8;
  localparam int DEF_NUM_SRC     = 4;
  localparam int DEF_DIV_BUS     = 32;
  localparam int DEF_TICK_DIV    = 50_000_000;
  localparam int DEF_DWELL_TICKS = 4;

endpackage

// File: rtl/led_display_scheduler_tick_gen.sv
// Free-running tick divider: one-cycle enable every TICK_DIV unpaused clk cycles.
module tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int DIV_BUS  = DEF_DIV_BUS,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_BUS-1:0] TERM = DIV_BUS'(TICK_DIV - 1);

  logic [DIV_BUS-1:0] tick_cnt;

  // Tick is decoded from the count so it lines up with the wrap cycle; paused cycles never tick.
  assign tick = en && (tick_cnt == TERM);

  // Count 0..TICK_DIV-1 while enabled, holding otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (en) begin
      if (tick_cnt == TERM) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + DIV_BUS'(1);
    end
  end

endmodule

// File: rtl/led_display_scheduler.sv
// Time-shares one LED bank between several pattern sources: round-robin with a
// tick-based dwell, source 0 preempts and keeps the bank until it lets go.
module led_display_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int DIV_BUS     = DEF_DIV_BUS,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DWELL_TICKS = DEF_DWELL_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC*N-1:0] src_pattern,
  input  logic                 pause,
  output logic [N-1:0]         outLED,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 grant_done,
  output logic                 tick
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [SW-1:0] LAST_SRC   = SW'(NUM_SRC - 1);

  // First requester after 'last', wrapping modulo NUM_SRC.
  function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                            input logic [SW-1:0]      last);
    logic [SW-1:0] pick;
    logic [SW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = SW'((int'(last) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  sched_state_t        state, state_n;
  logic [SW-1:0]       owner, owner_n;
  logic [SW-1:0]       rr_last, rr_last_n;
  logic [DW-1:0]       dwell_cnt, dwell_n;
  logic [N-1:0]        led_n;
  logic [NUM_SRC-1:0]  grant_n;
  logic                done_n;
  logic [N-1:0]        pat [NUM_SRC];
  logic [SW-1:0]       winner;
  logic                release_req, preempt, expire;

  tick_gen #(
    .DIV_BUS  (DIV_BUS),
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (~pause),
    .tick (tick)
  );

  // Unpack the flat pattern bus into one lane per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) pat[i] = src_pattern[i*N +: N];
  end

  assign winner      = src_req[0] ? '0 : rr_pick(src_req, rr_last);
  assign release_req = !src_req[owner];
  assign preempt     = (owner != '0) && src_req[0];
  assign expire      = (owner != '0) && tick && (dwell_cnt == DWELL_LAST);

  // Next-state and next-output decode; any combination of exit causes yields one exit.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    rr_last_n = rr_last;
    dwell_n   = dwell_cnt;
    led_n     = outLED;
    grant_n   = grant;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        led_n   = '0;
        grant_n = '0;
        if (|src_req) state_n = ARB;
      end
      ARB: begin
        if (|src_req) begin
          owner_n   = winner;
          rr_last_n = winner;
          dwell_n   = '0;
          grant_n   = NUM_SRC'(1) << winner;
          led_n     = pat[winner];
          state_n   = SHOW;
        end else begin
          grant_n = '0;
          led_n   = '0;
          state_n = IDLE;
        end
      end
      SHOW: begin
        if (release_req || preempt || expire) begin
          grant_n = '0;
          done_n  = 1'b1;
          state_n = ARB;
        end else begin
          led_n = pat[owner];
          // The urgent owner ignores dwell, so its count is left parked.
          if (tick && (owner != '0)) dwell_n = dwell_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any grant without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_last    <= LAST_SRC;
      dwell_cnt  <= '0;
      outLED     <= '0;
      grant      <= '0;
      grant_done <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      rr_last    <= rr_last_n;
      dwell_cnt  <= dwell_n;
      outLED     <= led_n;
      grant      <= grant_n;
      grant_done <= done_n;
    end
  end

endmodule

// File: tb/tb_led_display_scheduler.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs, a monitor compares.
module tb_led_display_scheduler;

  localparam int N   = 8;
  localparam int NS  = 4;
  localparam int TD  = 4;
  localparam int DWT = 2;

  localparam int PH_IDLE = 0;
  localparam int PH_ARB  = 1;
  localparam int PH_SHOW = 2;

  typedef struct packed {
    logic [NS-1:0] g;
    logic [N-1:0]  led;
    logic          done;
    logic          tk;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_req;
  logic [NS*N-1:0] src_pattern;
  logic            pause;
  logic [N-1:0]    outLED;
  logic [NS-1:0]   grant;
  logic            grant_done;
  logic            tick;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state, in plain integers.
  int            m_phase, m_owner, m_last, m_dwell, m_cnt;
  logic [NS-1:0] m_grant;
  logic [N-1:0]  m_led;
  logic          m_done;

  led_display_scheduler #(
    .N           (N),
    .NUM_SRC     (NS),
    .DIV_BUS     (32),
    .TICK_DIV    (TD),
    .DWELL_TICKS (DWT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_req     (src_req),
    .src_pattern (src_pattern),
    .pause       (pause),
    .outLED      (outLED),
    .grant       (grant),
    .grant_done  (grant_done),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  function automatic bit bitof(input logic [NS-1:0] v, input int i);
    return ((v >> i) & NS'(1)) != 0;
  endfunction

  function automatic logic [N-1:0] lane(input logic [NS*N-1:0] p, input int i);
    return N'(p >> (i * N));
  endfunction

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit t, rel, pre, expd;
    int w;
    if (rst) begin
      m_phase = PH_IDLE; m_owner = 0; m_last = NS - 1; m_dwell = 0; m_cnt = 0;
      m_grant = '0; m_led = '0; m_done = 1'b0;
    end else begin
      t = !pause && (m_cnt == TD - 1);
      if (!pause) m_cnt = (m_cnt + 1) % TD;
      m_done = 1'b0;
      case (m_phase)
        PH_IDLE: if (src_req != 0) m_phase = PH_ARB;
        PH_ARB: begin
          if (src_req == 0) begin
            m_grant = '0; m_led = '0; m_phase = PH_IDLE;
          end else begin
            w = -1;
            if (src_req[0]) w = 0;
            for (int k = 1; k <= NS; k++)
              if (w < 0 && bitof(src_req, (m_last + k) % NS)) w = (m_last + k) % NS;
            m_owner = w; m_last = w; m_dwell = 0;
            m_grant = NS'(1 << w);
            m_led   = lane(src_pattern, w);
            m_phase = PH_SHOW;
          end
        end
        default: begin
          rel  = !bitof(src_req, m_owner);
          pre  = (m_owner != 0) && src_req[0];
          expd = (m_owner != 0) && t && (m_dwell == DWT - 1);
          if (rel || pre || expd) begin
            m_grant = '0; m_done = 1'b1; m_phase = PH_ARB;
          end else begin
            m_led = lane(src_pattern, m_owner);
            if (t) m_dwell++;
          end
        end
      endcase
    end
  endtask

  // Drive one cycle: model the edge, apply new inputs, queue the expected outputs.
  task automatic run(input int cycles, input int mode);
    exp_t e;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      model_edge();
      rst   = 1'b0;
      pause = 1'b0;
      case (mode)
        0: begin rst = 1'b1; src_req = '0; end
        1: begin
          src_req = 4'b0100;
          if ($urandom_range(0, 3) == 0) src_pattern = $urandom();
          src_pattern[23:16] = 8'hA5;
        end
        2: begin src_req = 4'b1110; src_pattern = $urandom(); end
        3: begin
          if ($urandom_range(0, 5) == 0) begin
            src_req[0]    = ($urandom_range(0, 7) == 0);
            src_req[NS-1:1] = 3'($urandom());
          end
          if ($urandom_range(0, 3) == 0) src_pattern = $urandom();
          pause = ($urandom_range(0, 9) == 0);
          rst   = ($urandom_range(0, 79) == 0);
        end
        4: src_req = (c < 6) ? 4'b0100 : (c < 16) ? 4'b1101 : 4'b1100;
        5: begin src_req = 4'b0010; pause = (c >= 6 && c < 26); end
        6: begin
          src_req = 4'b0100;
          rst     = (c == 6);
          src_pattern[23:16] = (c < 12) ? 8'h01 : 8'h80;
        end
        default: src_req = '0;
      endcase
      e.g    = m_grant;
      e.led  = m_led;
      e.done = m_done;
      e.tk   = !pause && (m_cnt == TD - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if ({grant, outLED, grant_done, tick} !== mon_e) begin
        n_fail++;
        $display("FAIL cycle%0d outputs: got grant=%b led=%h done=%b tick=%b, want grant=%b led=%h done=%b tick=%b",
                 cyc, grant, outLED, grant_done, tick, mon_e.g, mon_e.led, mon_e.done, mon_e.tk);
      end
    end
  end

  initial begin
    rst = 1'b1; src_req = '0; src_pattern = '0; pause = 1'b0;
    run(2, 0);
    run(14, 9);
    run(40, 1);
    run(2, 0);
    run(70, 2);
    run(2, 0);
    run(30, 4);
    run(2, 0);
    run(40, 5);
    run(2, 0);
    run(20, 6);
    run(600, 3);
    run(20, 9);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
